// File: rtl/rv32_pkg.sv
// Shared RV32 encoding types for the instruction packer.
// Format codes, base opcodes and packer FSM states.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [31:0] imm;
    } fields_t;

endpackage

// File: rtl/ins_encoder.sv
// Combinational RV32 field packer.
// Branch/jump targets must be halfword aligned.
module ins_encoder
    import rv32_pkg::*;
(
    input  logic [2:0]  fmt,
    input  fields_t     f,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        unique case (fmt)
            FMT_R: word = {f.funct7, f.rs2, f.rs1, f.funct3,
                           f.rd, f.opcode};
            FMT_I: word = {f.imm[11:0], f.rs1, f.funct3,
                           f.rd, f.opcode};
            FMT_S: word = {f.imm[11:5], f.rs2, f.rs1, f.funct3,
                           f.imm[4:0], f.opcode};
            FMT_B: begin
                word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1,
                        f.funct3, f.imm[4:1], f.imm[11], f.opcode};
                illegal = f.imm[0];
            end
            FMT_U: word = {f.imm[31:12], f.rd, f.opcode};
            FMT_J: begin
                word = {f.imm[20], f.imm[10:1], f.imm[11],
                        f.imm[19:12], f.rd, f.opcode};
                illegal = f.imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/insn_packer.sv
// Streams field tuples into packed RV32 words at
// consecutive word addresses, one word per cycle.
module insn_packer
    import rv32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      ins_o,
    output logic [31:0]      addr_o,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] emitted
);

    state_e           state_q, state_d;
    logic [31:0]      addr_q;
    logic [CNT_W-1:0] rem_q;
    fields_t          f;
    logic [31:0]      word;
    logic             illegal;
    logic             acc, acc_ok, out_hs, load;

    assign f = '{funct7: funct7, rs2: rs2, rs1: rs1,
                 funct3: funct3, rd: rd, opcode: opcode,
                 imm: imm};

    ins_encoder u_enc (
        .fmt     (fmt),
        .f       (f),
        .word    (word),
        .illegal (illegal)
    );

    assign acc    = in_valid & in_ready;
    assign acc_ok = acc & ~illegal;
    assign out_hs = out_valid & out_ready;
    assign load   = (state_q == ST_IDLE) & start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start && len != '0) state_d = ST_RUN;
            ST_RUN:   if (acc_ok && rem_q == CNT_W'(1))
                          state_d = ST_DRAIN;
            ST_DRAIN: if (!out_valid || out_ready)
                          state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_RUN) && (rem_q != '0) &&
                   (!out_valid || out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            rem_q   <= '0;
            emitted <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (load && len == '0) ||
                    (state_q == ST_DRAIN &&
                     (!out_valid || out_ready));
            if (load) begin
                addr_q  <= base_addr & 32'hffff_fffc;
                rem_q   <= len;
                emitted <= '0;
                err     <= 1'b0;
            end else begin
                if (out_hs) begin
                    addr_q  <= addr_q + 32'd4;
                    emitted <= emitted + CNT_W'(1);
                end
                if (acc_ok)          rem_q <= rem_q - CNT_W'(1);
                if (acc && illegal)  err   <= 1'b1;
            end
        end
    end

    // A word loaded while the previous one leaves takes the next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ins_o     <= '0;
            addr_o    <= '0;
        end else if (acc_ok) begin
            out_valid <= 1'b1;
            ins_o     <= word;
            addr_o    <= out_hs ? addr_q + 32'd4 : addr_q;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/insn_packer.md
INSN_PACKER -- requirements
Module: insn_packer

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the word-count/length fields.
REQ-002 SHALL have port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  begin a packing run; sampled only in IDLE.
REQ-005 SHALL have port: base_addr  in  32  word address of the first emitted instruction; low 2 bits ignored, forced 0.
REQ-006 SHALL have port: len  in  CNT_W  number of instructions to emit in the run.
REQ-007 SHALL have port: in_valid / in_ready  in / out  1 / 1  field-tuple handshake.
REQ-008 SHALL have port: fmt  in  3  format code, R=0 I=1 S=2 B=3 U=4 J=5; 6 and 7 illegal.
REQ-009 SHALL have port: opcode, rd, funct3, rs1, rs2, funct7, imm  in  7, 5, 3, 5, 5, 7, 32  instruction fields.
REQ-010 SHALL have port: out_valid / out_ready  out / in  1 / 1  packed-word handshake.
REQ-011 SHALL have port: ins_o, addr_o  out  32, 32  packed instruction and its write address.
REQ-012 SHALL have port: done  out  1  one-cycle pulse at end of run.
REQ-013 SHALL have port: err, emitted  out  1, CNT_W  sticky error flag; count of words emitted this run.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DRAIN. IDLE->RUN on start with len!=0. IDLE stays IDLE on start with len==0, done pulses next cycle.
REQ-015 start SHALL load addr counter=base_addr, remaining=len, emitted=0, err=0.
REQ-016 in_ready SHALL be 1 only in RUN with remaining!=0 and (out_valid==0 or out_ready==1).
REQ-017 Packing SHALL be: R {funct7,rs2,rs1,funct3,rd,opcode}; I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-018 Packing SHALL be: B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U {imm[31:12],rd,opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-019 Unused fields for a format SHALL be ignored.
REQ-020 A legal accepted tuple SHALL appear registered on ins_o/addr_o with out_valid=1 exactly 1 cycle after acceptance.
REQ-021 Each legal acceptance SHALL decrement remaining.
REQ-022 A tuple SHALL be illegal if fmt>=6, or if fmt is B or J with imm[0]=1. An illegal tuple SHALL be consumed but not emitted, SHALL set err, and SHALL leave remaining unchanged.
REQ-023 out_valid, ins_o and addr_o SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 On each out handshake: addr counter += 4, wrapping modulo 2^32; emitted += 1.
REQ-025 Simultaneous out handshake and new acceptance SHALL be allowed in the same cycle (full throughput, 1 word/cycle).
REQ-026 When remaining reaches 0, FSM SHALL go RUN->DRAIN. DRAIN->IDLE SHALL occur on the final out handshake, or immediately if nothing is pending, with done=1 for that one cycle.
REQ-027 start SHALL be ignored in RUN and DRAIN.
REQ-028 err SHALL be cleared only by start or reset.

Reset
REQ-029 While rst_n=0, all state SHALL clear asynchronously: FSM=IDLE, out_valid=0, ins_o=0, addr_o=0, done=0, err=0, emitted=0, in_ready=0.
REQ-030 Reset mid-run SHALL discard any pending word; no done pulse SHALL follow.

Structure
REQ-031 The format enum (R,I,S,B,U,J), opcode constants and the FSM state typedef SHALL live in shared package rv32_pkg.
REQ-032 Packing SHALL be a combinational sub-module ins_encoder (fields in, 32-bit word and illegal flag out), the inverse of the decode-side field splitters.

Verification
REQ-033 R, opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0, base_addr=0x100, len=1 -> ins_o=0x002081B3, addr_o=0x100, then done pulse.
REQ-034 I addi, opcode=0x13, rd=1, rs1=0, imm=0xFFFFFFFF -> 0xFFF00093. B beq, opcode=0x63, rs1=rs2=0, imm=-4 -> 0xFE000EE3. J, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF.
REQ-035 len=4, out_ready held 0 for 3 cycles mid-run -> ins_o/addr_o stable, in_ready=0; addresses base, +4, +8, +12; emitted=4.
REQ-036 fmt=7 tuple, then B with imm=0x3, within len=2 -> both dropped, err=1, run completes only after 2 further legal words.
REQ-037 base_addr=0xFFFFFFFC, len=2 -> addr_o=0xFFFFFFFC, then 0x00000000.
REQ-038 rst_n low while out_valid=1 in RUN -> out_valid=0 immediately, FSM=IDLE, no done.
